// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, FSM states and ALU encoding for multicycle_cpu
//
// Purpose: common definitions imported by multicycle_cpu and regfile_param.
// Contents: OP_WIDTH, opcode constants, state_t, alu_op_t, writes_reg().
package cpu_pkg;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_JZ   = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_LI   = 4'b0101;
  localparam logic [OP_WIDTH-1:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_IMM} alu_op_t;

  // Opcodes that commit a result to rd; JZ, HALT and NOPs leave the file alone.
  function automatic logic writes_reg(input logic [OP_WIDTH-1:0] op);
    return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LI});
  endfunction

endpackage

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file, two async reads, debug read, one sync write
//
// Purpose: architectural registers of multicycle_cpu, cleared by async reset.
// Ports:
//   CLK, RST          clock, async active-high reset
//   ra_sel / ra_val   read port A (combinational)
//   rb_sel / rb_val   read port B (combinational)
//   dbg_sel / dbg_val debug read port (combinational)
//   we, wsel, wdata   synchronous write port
module regfile_param
  import cpu_pkg::*;
#(
  parameter int REG_WIDTH = 8,
  parameter int NUM_REGS  = 4,
  localparam int RIDX     = $clog2(NUM_REGS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [RIDX-1:0]      ra_sel,
  output logic [REG_WIDTH-1:0] ra_val,
  input  logic [RIDX-1:0]      rb_sel,
  output logic [REG_WIDTH-1:0] rb_val,
  input  logic [RIDX-1:0]      dbg_sel,
  output logic [REG_WIDTH-1:0] dbg_val,
  input  logic                 we,
  input  logic [RIDX-1:0]      wsel,
  input  logic [REG_WIDTH-1:0] wdata
);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wsel] <= wdata;
    end
  end

  assign ra_val  = regs[ra_sel];
  assign rb_val  = regs[rb_sel];
  assign dbg_val = regs[dbg_sel];

endmodule

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle core: req/ack instruction fetch, one-cycle execute, sticky halt
//
// Purpose: fetches from external instruction memory, executes ADD/SUB/AND/OR/JZ/LI/HALT.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   run                      gates the start of new fetches
//   imem_req/addr/ack/data   instruction fetch handshake
//   retire                   high for the EXEC cycle of each instruction
//   halted                   core is in HALTED
//   pc                       program counter
//   dbg_sel / dbg_val        combinational register observation
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int REG_WIDTH   = 8,
  parameter int NUM_REGS    = 4,
  parameter int ADDR_WIDTH  = 8,
  localparam int RIDX        = $clog2(NUM_REGS),
  localparam int INSTR_WIDTH = OP_WIDTH + 3 * RIDX
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   run,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   retire,
  output logic                   halted,
  output logic [ADDR_WIDTH-1:0]  pc,
  input  logic [RIDX-1:0]        dbg_sel,
  output logic [REG_WIDTH-1:0]   dbg_val
);

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;

  logic [OP_WIDTH-1:0]    op;
  logic [RIDX-1:0]        rs, rt, rd;
  logic [2*RIDX-1:0]      imm;
  logic [REG_WIDTH-1:0]   ra_val, rb_val, alu_y, li_val;
  logic [ADDR_WIDTH-1:0]  next_pc;
  alu_op_t                alu_op;
  logic                   reg_we;

  assign op  = ir[INSTR_WIDTH-1 -: OP_WIDTH];
  assign rs  = ir[3*RIDX-1 -: RIDX];
  assign rt  = ir[2*RIDX-1 -: RIDX];
  assign rd  = ir[RIDX-1:0];
  assign imm = {rs, rt};
  // Size cast zero-extends or truncates the {rs,rt} immediate as the widths demand.
  assign li_val = REG_WIDTH'(imm);

  // RST is folded in so the request drops the moment reset asserts.
  assign imem_req  = (state == FETCH) && run && !RST;
  assign imem_addr = pc;
  assign reg_we    = (state == EXEC) && writes_reg(op);

  regfile_param #(
    .REG_WIDTH(REG_WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .CLK    (CLK),
    .RST    (RST),
    .ra_sel (rs),
    .ra_val (ra_val),
    .rb_sel (rt),
    .rb_val (rb_val),
    .dbg_sel(dbg_sel),
    .dbg_val(dbg_val),
    .we     (reg_we),
    .wsel   (rd),
    .wdata  (alu_y)
  );

  always_comb begin
    alu_op  = ALU_IMM;
    next_pc = pc + ADDR_WIDTH'(1);
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_JZ:   if (ra_val == '0) next_pc = ADDR_WIDTH'(rb_val);
      OP_HALT: next_pc = pc;
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_y = ra_val + rb_val;
      ALU_SUB: alu_y = ra_val - rb_val;
      ALU_AND: alu_y = ra_val & rb_val;
      ALU_OR:  alu_y = ra_val | rb_val;
      default: alu_y = li_val;
    endcase
  end

  // retire and halted are registered alongside the state they describe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      retire <= 1'b0;
      halted <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (run && imem_ack) begin
            ir     <= imem_data;
            state  <= EXEC;
            retire <= 1'b1;
          end
        end
        EXEC: begin
          pc <= next_pc;
          if (op == OP_HALT) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state  <= FETCH;
          end
        end
        HALTED:  halted <= 1'b1;
        default: state  <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed, table-driven bench for multicycle_cpu
module tb_multicycle_cpu;

  logic       CLK, RST, run;
  logic       imem_req, imem_ack, retire, halted;
  logic [7:0] imem_addr, pc, dbg_val;
  logic [9:0] imem_data;
  logic [1:0] dbg_sel;

  logic        imem_req2, imem_ack2, retire2, halted2;
  logic [7:0]  imem_addr2, pc2;
  logic [12:0] imem_data2;
  logic [15:0] dbg_val2;
  logic [2:0]  dbg_sel2;

  logic [9:0]  mem  [256];
  logic [12:0] mem2 [256];
  int lat = 1;
  int wcnt = 0;
  int r2cnt = 0;
  int checks = 0;
  int errors = 0;

  multicycle_cpu dut (
    .CLK(CLK), .RST(RST), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .retire(retire), .halted(halted),
    .pc(pc), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  multicycle_cpu #(.REG_WIDTH(16), .NUM_REGS(8), .ADDR_WIDTH(8)) dut2 (
    .CLK(CLK), .RST(RST), .run(run), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_data(imem_data2), .retire(retire2), .halted(halted2),
    .pc(pc2), .dbg_sel(dbg_sel2), .dbg_val(dbg_val2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory stub: ack arrives in the lat-th cycle of a request.
  assign imem_ack  = imem_req && (wcnt == lat - 1);
  assign imem_data = mem[imem_addr];
  always @(posedge CLK) begin
    if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign imem_ack2  = imem_req2;
  assign imem_data2 = mem2[imem_addr2];
  always @(negedge CLK) begin
    if (RST) r2cnt <= 0;
    else if (retire2) r2cnt <= r2cnt + 1;
  end

  typedef struct {
    logic [3:0] op;
    logic [1:0] rs, rt, rd;
    logic [3:0] a, b;
    logic [1:0] chk;
    logic [7:0] exp_val;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [9:0] enc(input logic [3:0] op, input logic [1:0] rs, rt, rd);
    return {op, rs, rt, rd};
  endfunction

  function automatic logic [12:0] enc2(input logic [3:0] op, input logic [2:0] rs, rt, rd);
    return {op, rs, rt, rd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [9:0] w);
    for (int j = 0; j < 256; j++) mem[j] = w;
  endtask

  task automatic load_prog1();
    fill_mem(enc(4'hF, 0, 0, 0));
    mem[0] = enc(4'h5, 2'd0, 2'd3, 2'd1);
    mem[1] = enc(4'h5, 2'd0, 2'd2, 2'd2);
    mem[2] = enc(4'h0, 2'd1, 2'd2, 2'd3);
    mem[3] = enc(4'hF, 2'd0, 2'd0, 2'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_retires(input int n, output bit ok);
    int cnt = 0;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(negedge CLK);
      if (retire) cnt++;
    end
    ok = (cnt == n);
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge CLK);
      ok = halted;
    end
  endtask

  initial begin
    bit ok;
    int cnt, bad, rlen, cyc;
    bit started;
    logic [7:0] paddr;

    RST = 1'b1; run = 1'b1; dbg_sel = 2'd3; dbg_sel2 = 3'd3;
    load_prog1();
    for (int j = 0; j < 256; j++) mem2[j] = enc2(4'hF, 0, 0, 0);
    mem2[0] = enc2(4'h5, 3'd0, 3'd3, 3'd1);
    mem2[1] = enc2(4'h5, 3'd0, 3'd2, 3'd2);
    mem2[2] = enc2(4'h0, 3'd1, 3'd2, 3'd3);

    // Reset state, then first request in the first cycle out of reset
    @(posedge CLK); #1;
    check("rst_req", imem_req, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    @(negedge CLK); RST = 1'b0; #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);

    // Program 1, zero-wait; rd shows old value during the ADD's EXEC
    cnt = 0;
    for (int i = 0; i < 100 && !halted; i++) begin
      @(negedge CLK);
      if (retire) begin
        cnt++;
        if (cnt == 3) begin dbg_sel = 2'd3; #1; check("exec_old_val", dbg_val, 0); end
      end
    end
    check("p1_retires", cnt, 4);
    check("p1_halted", halted, 1);
    check("p1_pc", pc, 3);
    dbg_sel = 2'd3; #1;
    check("p1_r3", dbg_val, 8'h05);
    bad = 0;
    repeat (10) begin @(negedge CLK); if (imem_req || retire || !halted) bad++; end
    check("p1_halt_sticky", bad, 0);
    check("w16_retires", r2cnt, 4);
    check("w16_halted", halted2, 1);
    check("w16_pc", pc2, 3);
    check("w16_r3", dbg_val2, 16'h0005);

    // Single-instruction table: LI r1,a; LI r2,b; <op>; then inspect state
    vecs[0]  = '{4'h0, 2'd1, 2'd2, 2'd3, 4'd3,  4'd2,  2'd3, 8'h05, 8'h03};
    vecs[1]  = '{4'h1, 2'd1, 2'd2, 2'd3, 4'd2,  4'd3,  2'd3, 8'hFF, 8'h03};
    vecs[2]  = '{4'h2, 2'd1, 2'd2, 2'd3, 4'd12, 4'd10, 2'd3, 8'h08, 8'h03};
    vecs[3]  = '{4'h3, 2'd1, 2'd2, 2'd3, 4'd12, 4'd3,  2'd3, 8'h0F, 8'h03};
    vecs[4]  = '{4'h0, 2'd1, 2'd1, 2'd3, 4'd15, 4'd0,  2'd3, 8'h1E, 8'h03};
    vecs[5]  = '{4'h4, 2'd0, 2'd1, 2'd3, 4'd12, 4'd0,  2'd3, 8'h00, 8'h0C};
    vecs[6]  = '{4'h4, 2'd1, 2'd2, 2'd3, 4'd1,  4'd5,  2'd3, 8'h00, 8'h03};
    vecs[7]  = '{4'h5, 2'd3, 2'd3, 2'd3, 4'd0,  4'd0,  2'd3, 8'h0F, 8'h03};
    vecs[8]  = '{4'h6, 2'd1, 2'd2, 2'd3, 4'd3,  4'd2,  2'd3, 8'h00, 8'h03};
    vecs[9]  = '{4'h1, 2'd2, 2'd1, 2'd3, 4'd2,  4'd3,  2'd3, 8'h01, 8'h03};
    vecs[10] = '{4'hF, 2'd1, 2'd2, 2'd3, 4'd3,  4'd2,  2'd3, 8'h00, 8'h02};
    vecs[11] = '{4'h0, 2'd1, 2'd2, 2'd0, 4'd3,  4'd4,  2'd0, 8'h07, 8'h03};
    for (int v = 0; v < 12; v++) begin
      fill_mem(enc(4'hF, 0, 0, 0));
      mem[0] = enc(4'h5, vecs[v].a[3:2], vecs[v].a[1:0], 2'd1);
      mem[1] = enc(4'h5, vecs[v].b[3:2], vecs[v].b[1:0], 2'd2);
      mem[2] = enc(vecs[v].op, vecs[v].rs, vecs[v].rt, vecs[v].rd);
      do_reset();
      wait_retires(3, ok);
      check($sformatf("vec%0d_timeout", v), ok, 1);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      dbg_sel = vecs[v].chk; #1;
      check($sformatf("vec%0d_reg", v), dbg_val, vecs[v].exp_val);
    end

    // JZ to 0x10 built from LI r1,8; ADD r1,r1,r1; JZ r0,r1
    fill_mem(enc(4'hF, 0, 0, 0));
    mem[0] = enc(4'h5, 2'd2, 2'd0, 2'd1);
    mem[1] = enc(4'h0, 2'd1, 2'd1, 2'd1);
    mem[2] = enc(4'h4, 2'd0, 2'd1, 2'd0);
    do_reset();
    wait_retires(3, ok);
    check("jz10_timeout", ok, 1);
    @(posedge CLK); #1;
    check("jz10_addr", imem_addr, 8'h10);

    // 3-cycle ack latency: each request held 3 cycles at a stable address; 16 cycles total
    load_prog1();
    lat = 3;
    do_reset();
    #1;
    started = 0; rlen = 0; bad = 0; cyc = 0; paddr = '0;
    for (int i = 0; i < 200 && !halted; i++) begin
      if (imem_req) begin
        started = 1;
        rlen++;
        if (rlen > 1 && imem_addr != paddr) bad++;
        paddr = imem_addr;
        if (imem_ack) begin
          if (rlen != 3) bad++;
          rlen = 0;
        end
      end
      if (started && !halted) cyc++;
      @(negedge CLK);
    end
    check("lat3_req_shape", bad, 0);
    check("lat3_cycles", cyc, 16);
    check("lat3_halted", halted, 1);
    lat = 1;

    // run low for 5 cycles in FETCH after the first retire
    do_reset();
    wait_retires(1, ok);
    check("run_timeout", ok, 1);
    run = 1'b0;
    bad = 0;
    repeat (5) begin @(negedge CLK); if (imem_req || retire) bad++; end
    check("run_idle", bad, 0);
    check("run_pc", pc, 1);
    run = 1'b1;
    wait_halt(ok);
    check("run_resume_halt", ok, 1);
    dbg_sel = 2'd3; #1;
    check("run_resume_r3", dbg_val, 8'h05);
    check("run_resume_pc", pc, 3);

    // RST during the ADD's EXEC discards it
    do_reset();
    wait_retires(3, ok);
    check("rstx_timeout", ok, 1);
    RST = 1'b1; #1;
    check("rstx_retire", retire, 0);
    check("rstx_req", imem_req, 0);
    @(posedge CLK);
    @(negedge CLK); RST = 1'b0; #1;
    dbg_sel = 2'd3; #1;
    check("rstx_r3", dbg_val, 0);
    check("rstx_pc", pc, 0);
    check("rstx_refetch", {imem_req, imem_addr}, {1'b1, 8'h00});

    // PC wrap through 0xFF on NOPs
    fill_mem(enc(4'h6, 0, 0, 0));
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 1200 && !ok; i++) begin
      @(negedge CLK);
      ok = retire && (pc == 8'hFF);
    end
    check("wrap_reach_ff", ok, 1);
    @(posedge CLK); #1;
    check("wrap_addr", imem_addr, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor of the single-cycle core. It fetches each instruction from an external instruction memory over a req/ack handshake and executes it in a separate cycle. It also adds load-immediate, conditional jump and a sticky halt state. The block sits between the instruction memory (or a test stub) and the debug/observation logic of the top level.

## Interface
Parameters:
- REG_WIDTH, 8: data register width, ≥ 2
- NUM_REGS, 4: register count, power of two, ≥ 2; RIDX = clog2(NUM_REGS)
- ADDR_WIDTH, 8: PC / instruction address width
- Derived: INSTR_WIDTH = 4 + 3*RIDX

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  reset, asynchronous, active-high
- run  in  1  when low, no new fetch starts
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_WIDTH  fetch address (= pc)
- imem_ack  in  1  data valid this cycle
- imem_data  in  INSTR_WIDTH  instruction word
- retire  out  1  one-cycle pulse per executed instruction
- halted  out  1  core in HALTED state
- pc  out  ADDR_WIDTH  current program counter
- dbg_sel  in  RIDX  debug register select
- dbg_val  out  REG_WIDTH  reg_file[dbg_sel], combinational

## Operation
Instruction fields:
- op = instr[INSTR_WIDTH-1 -: 4]
- rs, rt, rd = next three RIDX-wide fields, MSB first

Opcodes:
- 0000 ADD: rd ← rs + rt
- 0001 SUB: rd ← rs − rt
- 0010 AND: rd ← rs & rt
- 0011 OR: rd ← rs | rt
- 0100 JZ: if reg[rs] == 0, pc ← reg[rt][ADDR_WIDTH-1:0] (zero-extended if REG_WIDTH < ADDR_WIDTH); else pc+1. No register write.
- 0101 LI: rd ← {rs,rt}, zero-extended to REG_WIDTH, or truncated if 2*RIDX > REG_WIDTH
- 1111 HALT: enter HALTED; pc unchanged
- All other opcodes: NOP, pc+1
- Arithmetic is modulo 2^REG_WIDTH; no flags.
- PC increments modulo 2^ADDR_WIDTH (wraps to 0).
- All registers are writable; there is no hardwired zero.

State machine (states FETCH, EXEC, HALTED):
- FETCH: imem_req = run. On run & imem_ack, latch imem_data into the instruction register and go to EXEC. Otherwise stay.
- EXEC: one cycle. Performs the register write and pc update and pulses retire. Next state is HALTED for HALT, else FETCH.
- HALTED: imem_req = 0 and halted = 1. Leaves only on RST.

Reset (async) values:
- state = FETCH, pc = 0, all registers 0
- imem_req = 0, retire = 0, halted = 0
- The instruction register is cleared to 0 (ADD r0,r0,r0; harmless).

## Timing
- imem_req is combinational from state and run. It rises in the first cycle after RST deasserts if run = 1.
- imem_ack may arrive in the same cycle as imem_req (zero-wait memory) or any number of cycles later.
- imem_addr and the request stay stable while imem_req is high.
- imem_ack is ignored when imem_req = 0.
- If run falls while waiting, imem_req drops. The fetch restarts from the same pc when run returns.
- Minimum 2 cycles per instruction: FETCH with ack, then EXEC. retire is high for the EXEC cycle only.
- The register write and pc update take effect at the rising edge that ends EXEC. dbg_val reflects the write from the following cycle.
- If dbg_sel equals the rd being written, dbg_val shows the old value during EXEC.
- RST asserted mid-fetch or mid-EXEC drops imem_req and retire asynchronously. The in-flight instruction is discarded with no register write.

## Structure
- Shared package cpu_pkg holds:
  - OP_WIDTH = 4
  - opcode constants OP_ADD … OP_HALT
  - state enum (FETCH/EXEC/HALTED)
  - ALU op encoding
- Sub-module regfile_param (REG_WIDTH, NUM_REGS):
  - two async read ports plus debug read port
  - one synchronous write port
  - async reset to 0
- ALU and decode stay inline in multicycle_cpu.

## Test plan
Defaults apply unless stated (REG_WIDTH=8, NUM_REGS=4, ADDR_WIDTH=8).
- Reset, zero-wait memory, program LI r1,3; LI r2,2; ADD r3,r1,r2; HALT -> r3 = 5. retire pulses exactly 4 times. halted = 1 and pc = 3. imem_req stays 0 thereafter.
- SUB of r1 = 2 minus r2 = 3 -> r3 = 0xFF (wrap). Then JZ r0,r1 with r0 = 0 and r1 = 0x10 -> next imem_addr = 0x10. JZ with a nonzero rs -> pc + 1.
- Memory with 3-cycle ack latency -> imem_req held with addr stable for 3 cycles. 4 instructions take 16 cycles from first req.
- run = 0 during FETCH for 5 cycles -> imem_req low, no retire, pc unchanged. Program resumes correctly when run = 1.
- RST pulsed in the cycle EXEC of an ADD would write r3 -> r3 stays 0, pc = 0, fetch restarts at address 0.
- pc = 0xFF executing NOP -> next imem_addr = 0x00. Repeat the first scenario with REG_WIDTH=16, NUM_REGS=8 -> identical results.
